// File: rtl/spi_pkg.sv
// Shared definitions for the register-access SPI link: frame layout,
// FSM state encodings and the frame builder used by both link ends.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 15;
    localparam int ADDR_LSB   = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Reads carry zeros in the data field so the slave sees a clean frame.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[RW_BIT] = rw;
        f[ADDR_LSB +: ADDR_W] = addr;
        if (rw) begin
            f[DATA_W-1:0] = wdata;
        end
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high on the last cycle of each
// CLK_DIV-cycle window; clear restarts the window.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one register request becomes one 16-bit frame.
// The FSM runs one cycle ahead of a registered output stage that drives the pins.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              spi_clk,
    output logic              spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    state_t                  state;
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-2:0]   tx;
    logic [DATA_W-1:0]       rx;
    logic                    rw_q;
    logic                    sclk_int;
    logic                    cs_int;
    logic                    mosi_int;
    logic                    busy_int;
    logic                    done_int;
    logic                    tick;
    logic                    div_clear;
    logic                    last_edge;
    logic                    accept;
    logic [FRAME_BITS-1:0]   frame;

    assign frame     = build_frame(rw, addr, wdata);
    assign last_edge = (bit_cnt == 5'd31);
    assign accept    = (state == ST_IDLE) && start && !busy;
    // Every state exit happens on a tick, so clearing there restarts the window on entry.
    assign div_clear = (state == ST_IDLE) || (tick && (state != ST_SHIFT || last_edge));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (div_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            tx       <= '0;
            rw_q     <= 1'b0;
            sclk_int <= 1'b0;
            cs_int   <= 1'b1;
            mosi_int <= 1'b0;
            busy_int <= 1'b0;
            done_int <= 1'b0;
        end else begin
            done_int <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx       <= frame[FRAME_BITS-2:0];
                        mosi_int <= frame[RW_BIT];
                        rw_q     <= rw;
                        cs_int   <= 1'b0;
                        busy_int <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sclk_int <= 1'b1;
                        bit_cnt  <= 5'd1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Odd edge count means the next edge is a falling one.
                    if (tick) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt[0]) begin
                            sclk_int <= 1'b0;
                            tx       <= {tx[FRAME_BITS-3:0], 1'b0};
                            if (last_edge) begin
                                mosi_int <= 1'b0;
                                state    <= ST_HOLD;
                            end else begin
                                mosi_int <= tx[FRAME_BITS-2];
                            end
                        end else begin
                            sclk_int <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_int <= 1'b1;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        busy_int <= 1'b0;
                        done_int <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MISO is sampled on the same clk edge that raises the spi_clk pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spi_clk  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            rx       <= '0;
        end else begin
            spi_clk  <= sclk_int;
            spi_cs   <= cs_int;
            spi_mosi <= mosi_int;
            busy     <= busy_int;
            done     <= done_int;
            if (sclk_int && !spi_clk) begin
                rx <= {rx[DATA_W-2:0], spi_miso};
            end
            if (done_int && !rw_q) begin
                rdata <= rx;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV 4 and 2), a pin
// monitor with a mode-0 slave model, and cycle-exact frame timing checks.
module tb_spi_master;

    localparam int CD0 = 4;
    localparam int CD1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [1:0] start;
    logic [1:0] rw;
    logic [3:0] addr [2];
    logic [7:0] wdata [2];
    wire  [1:0] busy, done, sclk, cs, mosi, miso;
    wire  [7:0] rdata0, rdata1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.CLK_DIV(CD0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .rw(rw[0]),
        .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]), .done(done[0]),
        .rdata(rdata0), .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0])
    );

    spi_master #(.CLK_DIV(CD1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .rw(rw[1]),
        .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]), .done(done[1]),
        .rdata(rdata1), .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1])
    );

    // Pin monitor and slave model, sampled on the inactive clock edge.
    logic [1:0]  mon_clr;
    logic [15:0] slv_word [2];
    logic [15:0] slv_sh [2];
    logic [15:0] cap [2];
    int          rises [2], falls [2], first_rise [2], last_fall [2];
    int          cs_fall [2], cs_fall_cnt [2], cs_rise [2];
    int          done_cnt [2], done_cyc [2];
    logic [1:0]  busy_at_done;
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_cs = 2'b11;

    for (genvar g = 0; g < 2; g++) begin : g_slave
        assign miso[g] = ~cs[g] & slv_sh[g][15];
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            prev_sclk[g] <= sclk[g];
            prev_cs[g]   <= cs[g];
            if (mon_clr[g]) begin
                slv_sh[g]      <= slv_word[g];
                cap[g]         <= '0;
                rises[g]       <= 0;
                falls[g]       <= 0;
                first_rise[g]  <= -1;
                last_fall[g]   <= -1;
                cs_fall[g]     <= -1;
                cs_fall_cnt[g] <= 0;
                cs_rise[g]     <= -1;
                done_cnt[g]    <= 0;
                done_cyc[g]    <= -1;
                busy_at_done[g] <= 1'b1;
            end else begin
                if (sclk[g] && !prev_sclk[g]) begin
                    rises[g] <= rises[g] + 1;
                    cap[g]   <= {cap[g][14:0], mosi[g]};
                    if (first_rise[g] < 0) first_rise[g] <= cyc;
                end
                if (!sclk[g] && prev_sclk[g]) begin
                    falls[g]     <= falls[g] + 1;
                    last_fall[g] <= cyc;
                    slv_sh[g]    <= {slv_sh[g][14:0], 1'b0};
                end
                if (!cs[g] && prev_cs[g]) begin
                    cs_fall[g]     <= cyc;
                    cs_fall_cnt[g] <= cs_fall_cnt[g] + 1;
                end
                if (cs[g] && !prev_cs[g] && cs_rise[g] < 0) begin
                    cs_rise[g] <= cyc;
                end
                if (done[g]) begin
                    done_cnt[g]     <= done_cnt[g] + 1;
                    done_cyc[g]     <= cyc;
                    busy_at_done[g] <= busy[g];
                end
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start is sampled at edge n; n is returned as the bench cycle index of that edge.
    task automatic launch(input int g, input logic r, input logic [3:0] a,
                          input logic [7:0] d, input logic [15:0] reply, output int n);
        rw[g] = r;
        addr[g] = a;
        wdata[g] = d;
        slv_word[g] = reply;
        mon_clr[g] = 1'b1;
        wait_cycles(1);
        mon_clr[g] = 1'b0;
        start[g] = 1'b1;
        wait_cycles(1);
        n = cyc;
        start[g] = 1'b0;
    endtask

    initial begin
        int n, n2, d_edge;
        rst_n = 2'b00;
        start = 2'b00;
        rw = 2'b00;
        addr[0] = '0; addr[1] = '0;
        wdata[0] = '0; wdata[1] = '0;
        slv_word[0] = '0; slv_word[1] = '0;
        mon_clr = 2'b11;
        wait_cycles(3);

        chk("rst_cs", 32'(cs), 32'h3);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", 32'(rdata0), 32'h0);
        rst_n = 2'b11;
        wait_cycles(2);

        // Write 0x3 <- 0xA5
        launch(0, 1'b1, 4'h3, 8'hA5, 16'h0000, n);
        wait_cycles(1);
        chk("wr_cs_low_n1", 32'(cs[0]), 32'h0);
        chk("wr_busy_n1", 32'(busy[0]), 32'h1);
        chk("wr_mosi_bit15", 32'(mosi[0]), 32'h1);
        wait_cycles(n + 140 - cyc);
        chk("wr_mosi_frame", 32'(cap[0]), 32'h83A5);
        chk("wr_rises", rises[0], 16);
        chk("wr_falls", falls[0], 16);
        chk("wr_first_rise", first_rise[0], n + 1 + CD0);
        chk("wr_last_fall", last_fall[0], n + 1 + 32 * CD0);
        chk("wr_cs_fall", cs_fall[0], n + 1);
        chk("wr_cs_rise", cs_rise[0], n + 133);
        chk("wr_done_cyc", done_cyc[0], n + 137);
        chk("wr_done_cnt", done_cnt[0], 1);
        chk("wr_busy_at_done", 32'(busy_at_done[0]), 32'h0);
        chk("wr_rdata", 32'(rdata0), 32'h0);

        // Read 0x5, slave returns 0x3C
        launch(0, 1'b0, 4'h5, 8'hFF, 16'h003C, n);
        wait_cycles(140);
        chk("rd_mosi_frame", 32'(cap[0]), 32'h0500);
        chk("rd_rdata", 32'(rdata0), 32'h3C);
        chk("rd_done_cyc", done_cyc[0], n + 137);
        chk("rd_busy_at_done", 32'(busy_at_done[0]), 32'h0);

        // Write with input changes after acceptance and a stray start at n+20
        launch(0, 1'b1, 4'h6, 8'h81, 16'h00E7, n);
        rw[0] = 1'b0;
        addr[0] = 4'hF;
        wdata[0] = 8'hFF;
        wait_cycles(19);
        start[0] = 1'b1;
        wait_cycles(1);
        start[0] = 1'b0;
        wait_cycles(n + 150 - cyc);
        chk("ign_mosi_frame", 32'(cap[0]), 32'h8681);
        chk("ign_rises", rises[0], 16);
        chk("ign_done_cnt", done_cnt[0], 1);
        chk("ign_cs_fall_cnt", cs_fall_cnt[0], 1);
        chk("ign_done_cyc", done_cyc[0], n + 137);
        chk("ign_rdata_kept", 32'(rdata0), 32'h3C);

        // Reset at n+50 mid-frame, then a clean read
        launch(0, 1'b0, 4'h5, 8'h00, 16'h003C, n);
        wait_cycles(49);
        rst_n[0] = 1'b0;
        wait_cycles(1);
        chk("abort_cs", 32'(cs[0]), 32'h1);
        chk("abort_sclk", 32'(sclk[0]), 32'h0);
        chk("abort_busy", 32'(busy[0]), 32'h0);
        chk("abort_done", 32'(done[0]), 32'h0);
        chk("abort_rdata", 32'(rdata0), 32'h0);
        rst_n[0] = 1'b1;
        wait_cycles(150);
        chk("abort_no_done", done_cnt[0], 0);
        launch(0, 1'b0, 4'hA, 8'h00, 16'h00C3, n);
        wait_cycles(140);
        chk("post_rd_frame", 32'(cap[0]), 32'h0A00);
        chk("post_rd_rdata", 32'(rdata0), 32'hC3);
        chk("post_rd_done_cyc", done_cyc[0], n + 137);

        // Back-to-back: start raised during the done cycle
        launch(0, 1'b1, 4'h1, 8'h22, 16'h0000, n);
        for (int i = 0; i < 200 && done[0] !== 1'b1; i++) wait_cycles(1);
        d_edge = cyc;
        chk("b2b_done_edge", d_edge, n + 137);
        rw[0] = 1'b1;
        addr[0] = 4'h9;
        wdata[0] = 8'h5A;
        start[0] = 1'b1;
        wait_cycles(1);
        n2 = cyc;
        start[0] = 1'b0;
        wait_cycles(n2 + 140 - cyc);
        chk("b2b_cs_fall", cs_fall[0], n2 + 1);
        chk("b2b_gap_ok", 32'((cs_fall[0] - cs_rise[0]) >= CD0 + 1), 32'h1);
        chk("b2b_cs_fall_cnt", cs_fall_cnt[0], 2);
        chk("b2b_frame2", 32'(cap[0]), 32'h895A);
        chk("b2b_done_cnt", done_cnt[0], 2);
        chk("b2b_done_cyc", done_cyc[0], n2 + 137);

        // CLK_DIV = 2: write 0xF <- 0x00
        launch(1, 1'b1, 4'hF, 8'h00, 16'h0000, n);
        wait_cycles(80);
        chk("cd2_frame", 32'(cap[1]), 32'h8F00);
        chk("cd2_rises", rises[1], 16);
        chk("cd2_first_rise", first_rise[1], n + 1 + CD1);
        chk("cd2_cs_fall", cs_fall[1], n + 1);
        chk("cd2_cs_rise", cs_rise[1], n + 67);
        chk("cd2_done_cyc", done_cyc[1], n + 69);
        chk("cd2_rdata", 32'(rdata1), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
